// File: rtl/minimig_autoconfig_pkg.sv
// Shared constants for the Minimig autoconfig controller: table slot bases,
// autoconfig register indices, controller state codes and the slot picker.
package minimig_autoconfig_pkg;

  localparam logic [8:0] SlotBaseZ2     = 9'h000;
  localparam logic [8:0] SlotBaseZ3Ram  = 9'h040;
  localparam logic [8:0] SlotBaseZ3Ram2 = 9'h080;
  localparam logic [8:0] SlotBaseZ3Ram3 = 9'h0C0;
  localparam logic [8:0] SlotBaseEth    = 9'h100;

  localparam logic [5:0] RegZero     = 6'h20;
  localparam logic [5:0] RegZ3Base   = 6'h22;
  localparam logic [5:0] RegZ2Base   = 6'h24;
  localparam logic [5:0] RegZ2BaseLo = 6'h25;
  localparam logic [5:0] RegShutup   = 6'h26;

  typedef logic [2:0] state_t;
  localparam state_t StInit0 = 3'd0;
  localparam state_t StInit1 = 3'd1;
  localparam state_t StScan  = 3'd2;
  localparam state_t StIdle  = 3'd3;
  localparam state_t StRd1   = 3'd4;
  localparam state_t StRd2   = 3'd5;
  localparam state_t StDone  = 3'd6;

  typedef logic [1:0] rd_kind_t;
  localparam rd_kind_t RdRom  = 2'd0;
  localparam rd_kind_t RdZero = 2'd1;
  localparam rd_kind_t RdOnes = 2'd2;

  // Returns {found, index} of the lowest set bit of avail at or above from.
  function automatic logic [3:0] pick_slot(input logic [7:0] avail, input logic [2:0] from);
    pick_slot = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (avail[i] && (3'(i) >= from)) pick_slot = {1'b1, 3'(i)};
    end
  endfunction

endpackage

// File: rtl/minimig_autoconfig_ctrl.sv
// Autoconfig chain controller: walks the enabled boards in slot order, serves nibble reads
// from the external table and latches the base addresses the OS writes back.
module minimig_autoconfig_ctrl
  import minimig_autoconfig_pkg::*;
#(
  parameter int unsigned SLOTS = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SLOTS-1:0] board_en,
  input  logic [3:0]       z2_size,
  input  logic [3:0]       z3c_size,
  input  logic             cpu_sel,
  input  logic             cpu_wr,
  input  logic [5:0]       cpu_reg,
  input  logic [15:0]      cpu_din,
  output logic [3:0]       cpu_dout,
  output logic             cpu_ack,
  output logic [8:0]       rom_raddr,
  input  logic [3:0]       rom_q,
  output logic             rom_we,
  output logic [8:0]       rom_waddr,
  output logic [3:0]       rom_d,
  output logic [3:0]       z2_base,
  output logic [2:0][7:0]  z3_base,
  output logic [15:0]      eth_base,
  output logic [SLOTS-1:0] cfgd,
  output logic             cfg_done
);

  state_t           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  logic [SLOTS-1:0] en_q, en_d, cfgd_q, cfgd_d, shut_q, shut_d;
  logic [3:0]       z2_base_q, z2_base_d, dout_q, dout_d;
  logic [2:0][7:0]  z3_base_q, z3_base_d;
  logic [15:0]      eth_base_q, eth_base_d;
  logic             done_q, done_d, ack_q, ack_d;
  logic [8:0]       raddr_q, raddr_d;
  rd_kind_t         rd_kind_q, rd_kind_d;
  logic [7:0]       avail;
  logic [3:0]       pick;
  logic [1:0]       z3_idx;

  assign z3_idx = 2'(slot_q - 3'd1);

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    en_d       = en_q;
    cfgd_d     = cfgd_q;
    shut_d     = shut_q;
    z2_base_d  = z2_base_q;
    z3_base_d  = z3_base_q;
    eth_base_d = eth_base_q;
    done_d     = done_q;
    ack_d      = 1'b0;
    dout_d     = dout_q;
    raddr_d    = raddr_q;
    rd_kind_d  = rd_kind_q;
    avail      = '0;
    avail[SLOTS-1:0] = en_q & ~cfgd_q & ~shut_q;
    pick       = pick_slot(avail, slot_q);

    case (state_q)
      StInit0: begin
        en_d    = board_en;
        state_d = StInit1;
      end
      StInit1: state_d = StScan;
      StScan: begin
        if (pick[3]) begin
          slot_d  = pick[2:0];
          state_d = StIdle;
        end else begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StIdle: begin
        if (cpu_sel && !cpu_wr) begin
          raddr_d   = {slot_q, cpu_reg};
          rd_kind_d = (cpu_reg[5:1] == RegZero[5:1]) ? RdZero : RdRom;
          state_d   = StRd1;
        end else if (cpu_sel) begin
          ack_d = 1'b1;
          // The Z2 low base nibble (reg 0x25) lies below the 1 MB granule: ack only.
          if (cpu_reg == RegShutup) begin
            shut_d[slot_q] = 1'b1;
            state_d        = StScan;
          end else if ((slot_q == 3'd0) && (cpu_reg == RegZ2Base)) begin
            z2_base_d = cpu_din[15:12];
            cfgd_d[0] = 1'b1;
            state_d   = StScan;
          end else if ((slot_q != 3'd0) && (cpu_reg == RegZ3Base)) begin
            if (slot_q == 3'd4) eth_base_d = cpu_din;
            else z3_base_d[z3_idx] = cpu_din[15:8];
            cfgd_d[slot_q] = 1'b1;
            state_d        = StScan;
          end
        end
      end
      StRd1: state_d = StRd2;
      StRd2: begin
        ack_d = 1'b1;
        case (rd_kind_q)
          RdZero:  dout_d = 4'b0000;
          RdOnes:  dout_d = 4'b1111;
          default: dout_d = rom_q;
        endcase
        state_d = done_q ? StDone : StIdle;
      end
      StDone: begin
        if (cpu_sel && !cpu_wr) begin
          rd_kind_d = RdOnes;
          state_d   = StRd1;
        end else if (cpu_sel) begin
          ack_d = 1'b1;
        end
      end
      default: state_d = StInit0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StInit0;
      slot_q     <= 3'd0;
      en_q       <= '0;
      cfgd_q     <= '0;
      shut_q     <= '0;
      z2_base_q  <= 4'h0;
      z3_base_q  <= '0;
      eth_base_q <= 16'h0000;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      dout_q     <= 4'b1111;
      raddr_q    <= 9'h000;
      rd_kind_q  <= RdRom;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      en_q       <= en_d;
      cfgd_q     <= cfgd_d;
      shut_q     <= shut_d;
      z2_base_q  <= z2_base_d;
      z3_base_q  <= z3_base_d;
      eth_base_q <= eth_base_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      raddr_q    <= raddr_d;
      rd_kind_q  <= rd_kind_d;
    end
  end

  // Qualified by reset_n so the table is never written while reset holds the FSM in INIT0.
  assign rom_we    = reset_n && ((state_q == StInit0) || (state_q == StInit1));
  assign rom_waddr = (state_q == StInit1) ? (SlotBaseZ3Ram3 | 9'h005) : (SlotBaseZ2 | 9'h001);
  assign rom_d     = (state_q == StInit1) ? z3c_size : z2_size;

  assign rom_raddr = raddr_q;
  assign cpu_dout  = dout_q;
  assign cpu_ack   = ack_q;
  assign z2_base   = z2_base_q;
  assign z3_base   = z3_base_q;
  assign eth_base  = eth_base_q;
  assign cfgd      = cfgd_q;
  assign cfg_done  = done_q;

endmodule
